// File: rtl/soc_bus_pkg.sv
// Shared definitions for the SoC bus fabric:
// FSM state encoding, default fault data and slave-count helpers.
package soc_bus_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   localparam logic [31:0] DEF_ERR_RDATA = 32'h0;
   localparam int          MAX_N_SLV     = 16;

   // Width of a slave index; never less than one bit.
   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/soc_addr_decode.sv
// Combinational base/mask address decoder.
// Lowest-index hit wins; flags writes to read-only slaves.
module soc_addr_decode
   import soc_bus_pkg::*;
#(
   parameter int                  N_SLV    = 6,
   parameter logic [32*N_SLV-1:0] SLV_BASE = '0,
   parameter logic [32*N_SLV-1:0] SLV_MASK = '0,
   parameter logic [N_SLV-1:0]    SLV_RO   = '0,
   parameter int                  SW       = sel_w(N_SLV)
)(
   input  logic [31:0]   i_addr,
   input  logic          i_wr,
   output logic          o_hit,
   output logic [SW-1:0] o_sel,
   output logic          o_ro_fault
);

   logic          w_hit;
   logic [SW-1:0] w_sel;

   // Scan from the top so the lowest matching index is kept last.
   always_comb begin
      w_hit = 1'b0;
      w_sel = '0;
      for (int i = N_SLV - 1; i >= 0; i--) begin
         if ((i_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
            w_hit = 1'b1;
            w_sel = SW'(i);
         end
      end
   end

   // A write that lands on a read-only slave is rejected.
   always_comb begin
      o_hit      = w_hit;
      o_sel      = w_sel;
      o_ro_fault = 1'b0;
      for (int i = 0; i < N_SLV; i++) begin
         if (w_sel == SW'(i))
            o_ro_fault = w_hit & i_wr & SLV_RO[i];
      end
   end

endmodule

// File: rtl/soc_bus_fabric.sv
// CPU-to-slaves interconnect with decode, timeout,
// read-only protection and fault reporting.
module soc_bus_fabric
   import soc_bus_pkg::*;
#(
   parameter int                  N_SLV     = 6,
   parameter logic [32*N_SLV-1:0] SLV_BASE  = '0,
   parameter logic [32*N_SLV-1:0] SLV_MASK  = '0,
   parameter logic [N_SLV-1:0]    SLV_RO    = '0,
   parameter int                  TIMEOUT   = 255,
   parameter logic [31:0]         ERR_RDATA = DEF_ERR_RDATA
)(
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 cpu_mem_valid,
   input  logic [31:0]          cpu_mem_addr,
   input  logic [3:0]           cpu_mem_wstrb,
   output logic                 cpu_mem_ready,
   output logic [31:0]          cpu_mem_rdata,
   output logic                 access_fault,
   output logic [N_SLV-1:0]     s_valid,
   input  logic [N_SLV-1:0]     s_ready,
   input  logic [32*N_SLV-1:0]  s_rdata,
   output logic [31:0]          err_addr,
   output logic [7:0]           err_count
);

   localparam int SW = sel_w(N_SLV);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST =
      CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t            r_state;
   state_t            w_next;
   logic [SW-1:0]     r_sel;
   logic [N_SLV-1:0]  r_svalid;
   logic [CW-1:0]     r_cnt;
   logic [31:0]       r_rdata;
   logic              r_fault;
   logic [31:0]       r_err_addr;
   logic [7:0]        r_err_count;

   logic              w_hit;
   logic [SW-1:0]     w_sel;
   logic              w_ro_fault;
   logic              w_legal;
   logic [N_SLV-1:0]  w_onehot;
   logic              w_srdy;
   logic [31:0]       w_srd;
   logic              w_timeout;
   logic              w_fault_now;

   soc_addr_decode #(
      .N_SLV    (N_SLV),
      .SLV_BASE (SLV_BASE),
      .SLV_MASK (SLV_MASK),
      .SLV_RO   (SLV_RO),
      .SW       (SW)
   ) u_dec (
      .i_addr     (cpu_mem_addr),
      .i_wr       (|cpu_mem_wstrb),
      .o_hit      (w_hit),
      .o_sel      (w_sel),
      .o_ro_fault (w_ro_fault)
   );

   assign w_legal   = w_hit & ~w_ro_fault;
   assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

   // One-hot request vector and selected-slave response mux.
   always_comb begin
      w_onehot = '0;
      w_srdy   = 1'b0;
      w_srd    = '0;
      for (int i = 0; i < N_SLV; i++) begin
         w_onehot[i] = (w_sel == SW'(i));
         if (r_sel == SW'(i)) begin
            w_srdy = s_ready[i];
            w_srd  = s_rdata[32*i +: 32];
         end
      end
   end

   // Fault events: decode failure in IDLE, or timeout without a late ready.
   always_comb begin
      w_fault_now = 1'b0;
      if (r_state == S_IDLE)
         w_fault_now = cpu_mem_valid & ~w_legal;
      else if (r_state == S_ACCESS)
         w_fault_now = ~w_srdy & w_timeout;
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (cpu_mem_valid)
               w_next = w_legal ? S_ACCESS : S_RESP;
         end
         S_ACCESS: begin
            if (w_srdy || w_timeout)
               w_next = S_RESP;
         end
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Outputs: response strobe only in RESP, fault gated by it.
   always_comb begin
      cpu_mem_ready = (r_state == S_RESP);
      access_fault  = (r_state == S_RESP) & r_fault;
      cpu_mem_rdata = r_rdata;
      s_valid       = r_svalid;
      err_addr      = r_err_addr;
      err_count     = r_err_count;
   end

   // Transaction datapath: select, slave request, counter, response data.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_sel    <= '0;
         r_svalid <= '0;
         r_cnt    <= '0;
         r_rdata  <= '0;
         r_fault  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cpu_mem_valid) begin
                  if (w_legal) begin
                     r_sel    <= w_sel;
                     r_svalid <= w_onehot;
                     r_cnt    <= '0;
                     r_fault  <= 1'b0;
                  end else begin
                     r_rdata  <= ERR_RDATA;
                     r_fault  <= 1'b1;
                  end
               end
            end
            S_ACCESS: begin
               if (w_srdy) begin
                  r_rdata  <= w_srd;
                  r_svalid <= '0;
                  r_fault  <= 1'b0;
               end else if (w_timeout) begin
                  r_rdata  <= ERR_RDATA;
                  r_svalid <= '0;
                  r_fault  <= 1'b1;
               end else begin
                  r_cnt    <= r_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Fault log: last faulting address and saturating count.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_err_addr  <= '0;
         r_err_count <= '0;
      end else if (w_fault_now) begin
         r_err_addr <= cpu_mem_addr;
         if (r_err_count != 8'hFF)
            r_err_count <= r_err_count + 8'd1;
      end
   end

endmodule
